mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameters: AW, 10, address width; DW, 20, RAM word width (one full cache block, two 10-bit halves).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset; ports are listed as name, direction, width, meaning.
REQ-003 clk  in  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 req0, req1  in  1 each  memory request from requester 0 / 1 (cache mem_req).
REQ-006 rw0, rw1  in  1 each  0 = read, 1 = write.
REQ-007 addr0, addr1  in  AW each  beat address; bit 0 = block-half (phase) bit.
REQ-008 wdata0, wdata1  in  DW each  write data.
REQ-009 ready0, ready1  out  1 each  one-cycle beat-complete pulse (cache mem_ready).
REQ-010 rdata0, rdata1  out  DW each  read data, valid only while the matching ready is high.
REQ-011 gnt  out  2  one-hot grant owner, bit0 = requester 0; 2'b00 when idle.
REQ-012 ram_we  out  1  synchronous RAM write enable.
REQ-013 ram_addr  out  AW  RAM address.
REQ-014 ram_wdata  out  DW  RAM write data.
REQ-015 ram_rdata  in  DW  RAM read data; valid one cycle after ram_addr is presented.

Function
REQ-016 The FSM SHALL have the states IDLE, ISSUE and DONE, plus an internal last-served pointer (lp) and a beat counter (bc, 0..1).
REQ-017 IDLE: if no req, stay. Otherwise select the owner, latch it into gnt, clear bc and go to ISSUE.
REQ-018 Owner selection: if only one req is high, that requester wins. If both are high, the requester other than lp wins (round-robin).
REQ-019 ISSUE: drive ram_addr = addrG, ram_wdata = wdataG and ram_we = rwG for exactly one cycle (G = owner), then go to DONE.
REQ-020 ISSUE: all ram_* outputs SHALL be 0 in every state other than ISSUE.
REQ-021 DONE: assert readyG for exactly this cycle. rdataG = ram_rdata if the beat is a read, else 0. The non-owner's ready and rdata are 0.
REQ-022 DONE exit, lock case: if reqG is high, addrG[0] = 0 and bc = 0, keep the grant, set bc = 1 and go to ISSUE (second beat of the block).
REQ-023 DONE exit, release case: otherwise go to IDLE, set lp = owner and set gnt = 0.
REQ-024 Lock bound: a grant SHALL cover at most 2 beats; after 2 beats the grant is released whatever the req/addr state.
REQ-025 Latency: req high in IDLE gives ISSUE the next cycle and ready the cycle after (2 cycles). A locked second beat gives ready 2 cycles after the first ready.
REQ-026 If reqG drops during ISSUE or DONE, the in-flight beat SHALL still complete (write committed, ready pulsed), and no further beat is issued.
REQ-027 A request arriving while the other requester owns the grant SHALL wait. It is served at the next IDLE, with no beat lost.
REQ-028 Requester inputs are sampled in the ISSUE cycle. Requesters hold addr, rw and wdata stable from req until ready.
REQ-029 gnt SHALL be one-hot or zero at all times. ready0 and ready1 SHALL never be high together.

Reset
REQ-030 While rst_n = 0, asynchronously: state = IDLE, gnt = 0, ready0/1 = 0, rdata0/1 = 0, ram_we = 0, ram_addr = 0, ram_wdata = 0, bc = 0, lp = 1 (so requester 0 wins the first tie).
REQ-031 Reset asserted mid-ISSUE SHALL drop ram_we immediately. No ready is issued for the aborted beat.
REQ-032 The first grant MAY occur on the first rising edge after rst_n rises.

Verification
REQ-033 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Reset mid-write: rst_n = 0 while ram_we = 1 -> ram_we, gnt and ready go to 0 in the same cycle, without waiting for a clock edge.
- Read block: req0 = 1, rw0 = 0, addr0 = 0x064, RAM holds 0x0ABCD at 0x064 -> ram_addr = 0x064 at cycle 1, ready0 = 1 with rdata0 = 0x0ABCD at cycle 2. addr0 = 0x065 next -> second ready0 at cycle 4, gnt = 01 throughout, then IDLE.
- Tie after reset: req0 = req1 = 1, both 2-beat -> requester 0's two beats first, then requester 1's. Next tie after that -> requester 0 first.
- Write: req1 = 1, rw1 = 1, addr1 = 0x0A0, wdata1 = 0x12345 -> ram_we = 1 for one cycle with ram_addr = 0x0A0 and ram_wdata = 0x12345; ready1 next cycle with rdata1 = 0.
- Lock bound: req0 held with addr0[0] = 0 continuously and req1 pending -> requester 0 released after 2 beats, requester 1 granted next.
- Request drop: req0 falls after the first ready0 with addr0[0] = 0 -> FSM returns to IDLE, and no second ram access occurs.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of one synchronous single-port RAM.
// A grant covers one beat, or two beats when a block's even half is followed by its odd half.
module mem_arbiter #(
  parameter int AW = 10,
  parameter int DW = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          rw0,
  input  logic          rw1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ready0,
  output logic          ready1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [1:0]    gnt,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0] r_state;
  logic [1:0] r_gnt;
  logic       r_lp;
  logic       r_bc;
  logic       r_rw;
  logic       r_phase;

  logic          w_own1;
  logic          w_req_g;
  logic          w_rw_g;
  logic [AW-1:0] w_addr_g;
  logic [DW-1:0] w_wdata_g;
  logic          w_pick1;
  logic          w_issue;
  logic          w_done;
  logic          w_lock;

  assign w_own1    = r_gnt[1];
  assign w_req_g   = w_own1 ? req1   : req0;
  assign w_rw_g    = w_own1 ? rw1    : rw0;
  assign w_addr_g  = w_own1 ? addr1  : addr0;
  assign w_wdata_g = w_own1 ? wdata1 : wdata0;

  // On a tie the requester that was not served last wins.
  assign w_pick1 = req1 & (~req0 | ~r_lp);

  assign w_issue = (r_state == S_ISSUE);
  assign w_done  = (r_state == S_DONE);
  assign w_lock  = w_req_g & ~r_phase & ~r_bc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_gnt   <= 2'b00;
      r_lp    <= 1'b1;
      r_bc    <= 1'b0;
      r_rw    <= 1'b0;
      r_phase <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every branch reads pre-edge state.
      case (r_state)
        S_IDLE: begin
          if (req0 | req1) begin
            r_gnt   <= {w_pick1, ~w_pick1};
            r_bc    <= 1'b0;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_rw    <= w_rw_g;
          r_phase <= w_addr_g[0];
          r_state <= S_DONE;
        end
        S_DONE: begin
          if (w_lock) begin
            r_bc    <= 1'b1;
            r_state <= S_ISSUE;
          end else begin
            r_lp    <= w_own1;
            r_gnt   <= 2'b00;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_gnt   <= 2'b00;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // NOTE: RAM strobes and ready are decoded from state rather than registered,
  // so the asynchronous reset of the state clears them without waiting for an edge.
  assign ram_we    = w_issue & w_rw_g;
  assign ram_addr  = w_issue ? w_addr_g  : '0;
  assign ram_wdata = w_issue ? w_wdata_g : '0;

  assign ready0 = w_done & r_gnt[0];
  assign ready1 = w_done & r_gnt[1];
  assign rdata0 = (ready0 & ~r_rw) ? ram_rdata : '0;
  assign rdata1 = (ready1 & ~r_rw) ? ram_rdata : '0;

  assign gnt = r_gnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a synchronous RAM model with a backdoor preload
// port, and one task per scenario checking outputs on the falling clock edge.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, rw0, rw1;
  logic [9:0]  addr0, addr1;
  logic [19:0] wdata0, wdata1;
  logic        ready0, ready1;
  logic [19:0] rdata0, rdata1;
  logic [1:0]  gnt;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic [19:0] ram_wdata;
  logic [19:0] ram_rdata;

  logic        bd_we;
  logic [9:0]  bd_addr;
  logic [19:0] bd_data;
  logic [19:0] mem [0:1023];

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.AW(10), .DW(20)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ready0(ready0), .ready1(ready1), .rdata0(rdata0), .rdata1(rdata1),
    .gnt(gnt), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic preload(input logic [9:0] a, input logic [19:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // Waits up to max_wait falling edges for an ISSUE cycle, checks it, then checks the DONE cycle.
  // Returns at the DONE falling edge so the caller can update requester inputs.
  task automatic beat(input int who, input int max_wait, input logic [9:0] ea,
                      input logic ewe, input logic [19:0] ewd, input logic [19:0] erd,
                      input string nm);
    bit found = 0;
    logic [1:0] egnt;
    egnt = (who == 1) ? 2'b10 : 2'b01;
    for (int n = 0; n < max_wait && !found; n++) begin
      @(negedge clk);
      if (gnt != 2'b00 && !ready0 && !ready1) found = 1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL %s_issue: no ISSUE cycle within %0d cycles", nm, max_wait);
    end else begin
      total++;
      if (gnt !== egnt) begin bad++; $display("FAIL %s_gnt: got %b exp %b", nm, gnt, egnt); end
      total++;
      if (ram_addr !== ea) begin bad++; $display("FAIL %s_ram_addr: got %h exp %h", nm, ram_addr, ea); end
      total++;
      if (ram_we !== ewe) begin bad++; $display("FAIL %s_ram_we: got %b exp %b", nm, ram_we, ewe); end
      total++;
      if (ram_wdata !== ewd) begin bad++; $display("FAIL %s_ram_wdata: got %h exp %h", nm, ram_wdata, ewd); end
      @(negedge clk);
      total++;
      if ({ready1, ready0} !== egnt) begin
        bad++; $display("FAIL %s_ready: got r1r0=%b exp %b", nm, {ready1, ready0}, egnt);
      end
      total++;
      if ((who == 1 ? rdata1 : rdata0) !== erd) begin
        bad++; $display("FAIL %s_rdata: got %h exp %h", nm, (who == 1 ? rdata1 : rdata0), erd);
      end
      total++;
      if ((who == 1 ? rdata0 : rdata1) !== 20'h0) begin
        bad++; $display("FAIL %s_other_rdata: got %h exp 0", nm, (who == 1 ? rdata0 : rdata1));
      end
      total++;
      if (ram_we !== 1'b0 || ram_addr !== 10'h0) begin
        bad++; $display("FAIL %s_ram_idle_in_done: got we=%b addr=%h exp 0/0", nm, ram_we, ram_addr);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req0 = 0; req1 = 0; rw0 = 0; rw1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    bd_we = 0; bd_addr = '0; bd_data = '0;
    @(negedge clk);
    preload(10'h064, 20'h0ABCD);
    preload(10'h065, 20'h11111);
    preload(10'h100, 20'h22222);
    preload(10'h101, 20'h33333);
    preload(10'h0B0, 20'h0DEAD);
    total++;
    if ({gnt, ready0, ready1, ram_we} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl: got gnt=%b r0=%b r1=%b we=%b exp all 0", gnt, ready0, ready1, ram_we);
    end
    total++;
    if ({ram_addr, ram_wdata, rdata0, rdata1} !== 70'h0) begin
      bad++; $display("FAIL reset_data: got addr=%h wd=%h rd0=%h rd1=%h exp 0", ram_addr, ram_wdata, rdata0, rdata1);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (gnt !== 2'b00) begin bad++; $display("FAIL reset_idle_gnt: got %b exp 00", gnt); end
  endtask

  task automatic test_reset_mid_write;
    req1 = 1; rw1 = 1; addr1 = 10'h0B0; wdata1 = 20'h55555;
    @(negedge clk);
    total++;
    if (ram_we !== 1'b1) begin bad++; $display("FAIL midrst_pre_we: got %b exp 1", ram_we); end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({ram_we, gnt, ready0, ready1} !== 5'b0 || ram_addr !== 10'h0) begin
      bad++; $display("FAIL midrst_async: got we=%b gnt=%b r0=%b r1=%b addr=%h exp 0", ram_we, gnt, ready0, ready1, ram_addr);
    end
    req1 = 0; rw1 = 0; addr1 = '0; wdata1 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({ready0, ready1, gnt} !== 4'b0) begin
      bad++; $display("FAIL midrst_no_ready: got r0=%b r1=%b gnt=%b exp 0", ready0, ready1, gnt);
    end
  endtask

  task automatic test_tie;
    req0 = 1; rw0 = 0; addr0 = 10'h064;
    req1 = 1; rw1 = 0; addr1 = 10'h100;
    beat(0, 1, 10'h064, 0, 20'h0, 20'h0ABCD, "tie1_r0b0");
    addr0 = 10'h065;
    beat(0, 1, 10'h065, 0, 20'h0, 20'h11111, "tie1_r0b1");
    req0 = 0;
    beat(1, 2, 10'h100, 0, 20'h0, 20'h22222, "tie1_r1b0");
    addr1 = 10'h101;
    beat(1, 1, 10'h101, 0, 20'h0, 20'h33333, "tie1_r1b1");
    req0 = 1; addr0 = 10'h064;
    req1 = 1; addr1 = 10'h100;
    beat(0, 2, 10'h064, 0, 20'h0, 20'h0ABCD, "tie2_r0");
    req0 = 0;
    beat(1, 2, 10'h100, 0, 20'h0, 20'h22222, "tie2_r1");
    req1 = 0;
    @(negedge clk);
  endtask

  task automatic test_read_block;
    @(negedge clk);
    req0 = 1; rw0 = 0; addr0 = 10'h064;
    beat(0, 1, 10'h064, 0, 20'h0, 20'h0ABCD, "rdblk_b0");
    addr0 = 10'h065;
    beat(0, 1, 10'h065, 0, 20'h0, 20'h11111, "rdblk_b1");
    req0 = 0;
    @(negedge clk);
    total++;
    if (gnt !== 2'b00 || ready0 !== 1'b0) begin
      bad++; $display("FAIL rdblk_release: got gnt=%b r0=%b exp 00/0", gnt, ready0);
    end
  endtask

  task automatic test_write;
    req1 = 1; rw1 = 1; addr1 = 10'h0A0; wdata1 = 20'h12345;
    beat(1, 1, 10'h0A0, 1, 20'h12345, 20'h0, "write");
    req1 = 0;
    @(negedge clk);
    req1 = 1; rw1 = 0; wdata1 = '0;
    beat(1, 1, 10'h0A0, 0, 20'h0, 20'h12345, "write_readback");
    req1 = 0;
    @(negedge clk);
  endtask

  task automatic test_lock_bound;
    req0 = 1; rw0 = 0; addr0 = 10'h064;
    req1 = 1; rw1 = 0; addr1 = 10'h100;
    beat(0, 1, 10'h064, 0, 20'h0, 20'h0ABCD, "lock_b0");
    beat(0, 1, 10'h064, 0, 20'h0, 20'h0ABCD, "lock_b1");
    beat(1, 2, 10'h100, 0, 20'h0, 20'h22222, "lock_handoff");
    req0 = 0; req1 = 0;
    @(negedge clk);
  endtask

  task automatic test_request_drop;
    req0 = 1; rw0 = 0; addr0 = 10'h064;
    beat(0, 2, 10'h064, 0, 20'h0, 20'h0ABCD, "drop_b0");
    req0 = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (gnt !== 2'b00 || ram_addr !== 10'h0 || ready0 !== 1'b0) begin
        bad++; $display("FAIL drop_idle_%0d: got gnt=%b addr=%h r0=%b exp 00/0/0", i, gnt, ram_addr, ready0);
      end
    end
    req0 = 1; addr0 = 10'h0B0;
    beat(0, 2, 10'h0B0, 0, 20'h0, 20'h0DEAD, "aborted_write_not_committed");
    req0 = 0;
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_reset_mid_write;
    test_tie;
    test_read_block;
    test_write;
    test_lock_bound;
    test_request_drop;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
